delay_line_v3: RTL

//  Parametrised multi-lane delay line with valid tracking, stall, flush and run-time delay select.

---
 rtl/delay_line_v3_pkg.sv | 19 +
 rtl/delay_line_v3_stage.sv | 35 +++
 rtl/delay_line_v3.sv | 73 +++++++
 3 files changed

// File: rtl/delay_line_v3_pkg.sv
// Shared constants and helpers for the multi-lane delay line.
package delay_pkg;

  // Hard upper bound on the number of register stages.
  localparam int MAX_DEPTH_LIMIT = 64;

  // Map a requested delay onto the legal range 1..max_depth.
  function automatic int clamp_delay(input int sel, input int max_depth);
    if (sel < 1)         return 1;
    if (sel > max_depth) return max_depth;
    return sel;
  endfunction

  // LSB position of a lane inside a packed multi-lane word.
  function automatic int lane_lsb(input int lane, input int bitsize);
    return lane * bitsize;
  endfunction

endpackage

// File: rtl/delay_line_v3_stage.sv
// One delay-line stage: a data register plus its valid bit.
module delay_stage #(
  parameter int W = 20
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         i_en,
  input  logic         i_flush,
  input  logic [W-1:0] i_data,
  input  logic         i_valid,
  output logic [W-1:0] o_data,
  output logic         o_valid
);

  logic [W-1:0] r_data;
  logic         r_valid;

  // Flush clears the valid bit only; data advances on en unless a flush is in progress.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: data registers are reset too, so out_data reads 0 during and after reset.
    if (!rst_n) begin
      r_data  <= '0;
      r_valid <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments let every stage sample its neighbour's old value.
      if (i_flush)   r_valid <= 1'b0;
      else if (i_en) r_valid <= i_valid;
      if (i_en && !i_flush) r_data <= i_data;
    end
  end

  assign o_data  = r_data;
  assign o_valid = r_valid;

endmodule

// File: rtl/delay_line_v3.sv
// Multi-lane delay line with run-time selectable tap, stall, flush and busy tracking.
module delay_line_v3
  import delay_pkg::*;
#(
  parameter  int BITSIZE   = 20,
  parameter  int LANES     = 1,
  parameter  int MAX_DEPTH = 8,
  localparam int DELW      = $clog2(MAX_DEPTH + 1),
  localparam int W         = LANES * BITSIZE
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            en,
  input  logic            flush,
  input  logic [DELW-1:0] delay_sel,
  input  logic            in_valid,
  input  logic [W-1:0]    in_data,
  output logic            out_valid,
  output logic [W-1:0]    out_data,
  output logic            busy
);

  if (MAX_DEPTH < 1 || MAX_DEPTH > MAX_DEPTH_LIMIT) begin : g_bad_depth
    $error("delay_line_v3: MAX_DEPTH must be in 1..64");
  end

  logic [W-1:0]         w_stage_data [MAX_DEPTH];
  logic [MAX_DEPTH-1:0] w_stage_valid;
  int                   w_tap;

  for (genvar k = 0; k < MAX_DEPTH; k++) begin : g_stage
    logic [W-1:0] w_prev_data;
    logic         w_prev_valid;

    if (k == 0) begin : g_head
      assign w_prev_data  = in_data;
      assign w_prev_valid = in_valid;
    end else begin : g_chain
      assign w_prev_data  = w_stage_data[k-1];
      assign w_prev_valid = w_stage_valid[k-1];
    end

    delay_stage #(.W(W)) u_stage (
      .clk     (clk),
      .rst_n   (rst_n),
      .i_en    (en),
      .i_flush (flush),
      .i_data  (w_prev_data),
      .i_valid (w_prev_valid),
      .o_data  (w_stage_data[k]),
      .o_valid (w_stage_valid[k])
    );
  end

  // Zero-based index of the stage whose contents drive the outputs.
  assign w_tap = clamp_delay(int'(delay_sel), MAX_DEPTH) - 1;

  // Combinational tap mux over the registered stages; no output register.
  always_comb begin
    // NOTE: defaults first so no path through the loop can infer a latch.
    out_data  = '0;
    out_valid = 1'b0;
    for (int k = 0; k < MAX_DEPTH; k++) begin
      if (k == w_tap) begin
        out_data  = w_stage_data[k];
        out_valid = w_stage_valid[k];
      end
    end
  end

  assign busy = |w_stage_valid;

endmodule
